cmd_host: RTL and testbench
===========================

Name: cmd_host

Overview:
- Synthesizable host-side initiator for the byte-level UART command protocol served by ram_rw (CPU_RST/CPU_RUN/CONF_WR/CONF_RD/DATA_WR/DATA_RD).
- Accepts one command request, serializes the opcode and payload into a uart_tx byte stream, then collects response bytes from a uart_rx byte stream.
- Replaces hand-written byte tables in benches and lets an on-board controller drive a remote hxdsoc over UART.

Parameters:
- XLEN, 32, width of each configuration word and of the transfer length.
- TIMEOUT_CYCLES, 32'd1_000_000, receive-idle limit in clocks; used only with CMD_HOST_TIMEOUT_EN.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  reset, asynchronous, active-low
- req_cmd_i  in  8  opcode, cmd_t value
- req_conf_i  in  2*XLEN  CONF_WR payload; word0 = [XLEN-1:0], word1 = [2*XLEN-1:XLEN]
- req_len_i  in  XLEN  byte count for DATA_WR/DATA_RD
- req_vld_i  in  1  request valid
- req_rdy_o  out  1  ready for a request (high only in IDLE)
- wr_data_i  in  8  DATA_WR payload byte
- wr_data_vld_i  in  1  payload byte valid
- wr_data_rdy_o  out  1  payload byte accepted
- uart_tx_data_o  out  8  byte to the transmitter
- uart_tx_data_vld_o  out  1  byte valid
- uart_tx_data_rdy_i  in  1  transmitter ready
- uart_rx_data_i  in  8  byte from the receiver
- uart_rx_data_vld_i  in  1  received byte valid
- uart_rx_data_rdy_o  out  1  receive byte consumed
- rd_data_o  out  8  response byte (CONF_RD/DATA_RD)
- rd_data_vld_o  out  1  one-cycle strobe per response byte
- done_o  out  1  one-cycle pulse at command completion
- err_o  out  1  one-cycle pulse on timeout abort (tied 0 without the macro)

Behaviour:
- All handshakes transfer on the cycle where vld && rdy are both high. The source holds vld and data stable until transfer.
- Reset values: every output 0 except req_rdy_o = 1. State = IDLE. Counters = 0.
- Async reset mid-operation returns to IDLE immediately. The partial frame is discarded and no done_o is generated.
- States and transitions:
  - IDLE: on req_vld_i && req_rdy_o, latch cmd, conf and len, then go to CMD.
  - CMD: drive the opcode with uart_tx_data_vld_o = 1. On transfer:
    - CONF_WR -> CONF.
    - DATA_WR -> WDATA if len != 0.
    - CONF_RD -> RDATA with count 8.
    - DATA_RD -> RDATA with count len if len != 0.
    - All other cases -> DONE.
  - CONF: send 8 bytes — word0 LSB-first, then word1 LSB-first. The byte index increments on each transfer. After the 8th byte -> DONE.
  - WDATA: uart_tx_data_o = wr_data_i, uart_tx_data_vld_o = wr_data_vld_i, wr_data_rdy_o = uart_tx_data_rdy_i (pass-through, zero latency). The down-counter decrements on each transfer; reaching 0 -> DONE.
  - RDATA: uart_rx_data_rdy_o = 1. Each received byte is registered to rd_data_o and rd_data_vld_o pulses the next cycle (latency 1). The counter decrements; on the last byte -> DONE.
  - DONE: done_o = 1 for one cycle, then IDLE.
- Opcodes other than the six listed are sent as a single byte, followed by DONE.
- uart_rx_data_rdy_o = 0 outside RDATA. Stray bytes stay pending in the receiver and are not consumed.
- len is counted as unsigned XLEN. len = 0 for DATA_WR/DATA_RD sends only the opcode. len = 2^XLEN-1 must count without wrap.
- A request arriving while busy is held off by req_rdy_o = 0 and never dropped.
- uart_tx_data_vld_o never asserts in RDATA. uart_rx_data_rdy_o never asserts in CMD/CONF/WDATA.

Optional Feature:
- Macro CMD_HOST_TIMEOUT_EN.
- When defined: in RDATA, a counter resets on every received byte and on entry. Reaching TIMEOUT_CYCLES pulses err_o and done_o together and returns to IDLE.
- When undefined: RDATA waits indefinitely, err_o is constant 0 and no timer logic is built.

Decomposition:
- Shared package cmd_pkg: cmd_t enum (CPU_RST=8'h2a, CPU_RUN=8'h2b, CONF_WR=8'h2c, CONF_RD=8'h2d, DATA_WR=8'h2e, DATA_RD=8'h2f), CONF_BYTES = 8, and the state enum.
- One natural sub-module: cmd_host_timer (timeout counter), instantiated only under CMD_HOST_TIMEOUT_EN.

Test Plan:
- CPU_RST request -> tx stream exactly {2a}; done_o one cycle after the tx transfer; rx untouched.
- CONF_WR, req_conf_i = {32'h0000_001f, 32'h4000_0000} -> tx {2c,00,00,00,40,1f,00,00,00}; done_o once.
- DATA_WR, len = 4, bytes aa bb cc dd with wr_data_vld_i gapped and uart_tx_data_rdy_i toggling -> tx {2e,aa,bb,cc,dd} in order, none duplicated.
- DATA_RD, len = 3, receiver returns 11 22 33 -> tx {2f}; rd_data_vld_o three strobes carrying 11, 22, 33; done_o after the third.
- Reset asserted during CONF byte 4, then CPU_RUN request -> outputs at reset values; next tx stream is {2b} only.
- With CMD_HOST_TIMEOUT_EN and TIMEOUT_CYCLES = 100: CONF_RD with no reply -> err_o and done_o pulse at cycle 100 of RDATA; req_rdy_o = 1 on the next cycle.

Source files
------------

// File: rtl/cmd_pkg.sv
// Shared types for the UART command host: opcode encoding, config frame size, FSM states.
// Latency: n/a (package).
// Backpressure: n/a (package).
package cmd_pkg;

  // Opcodes understood by the remote ram_rw command server.
  typedef enum logic [7:0] {
    CPU_RST = 8'h2a,
    CPU_RUN = 8'h2b,
    CONF_WR = 8'h2c,
    CONF_RD = 8'h2d,
    DATA_WR = 8'h2e,
    DATA_RD = 8'h2f
  } cmd_t;

  // A configuration frame is two 32-bit words sent as 8 bytes.
  localparam int CONF_BYTES = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_CONF,
    ST_WDATA,
    ST_RDATA,
    ST_DONE
  } state_t;

endpackage

// File: rtl/cmd_host_timer.sv
// Receive-idle watchdog: counts cycles while running, cleared when stopped or on clr_i.
// Latency: expired_o is combinational from the count, high on the TIMEOUT_CYCLES-th running cycle.
// Backpressure: none; free-running counter.
//
// Ports:
//   clk_i, rst_n_i : clock, async active-low reset
//   run_i          : count enable (host is waiting for response bytes)
//   clr_i          : restart the count (a byte arrived)
//   expired_o      : idle limit reached this cycle
module cmd_host_timer #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic run_i,
  input  logic clr_i,
  output logic expired_o
);

  logic [31:0] cnt_q;

  // Count is held at zero whenever not running, so every entry starts fresh.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (!run_i || clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign expired_o = run_i && !clr_i && (cnt_q == TIMEOUT_CYCLES - 32'd1);

endmodule

// File: rtl/cmd_host.sv
// Host-side initiator for the ram_rw UART command protocol (opcode, payload out; response bytes in).
// Latency: opcode offered the cycle after request accept; write payload passes through with zero latency; rd_data_o one cycle after rx byte.
// Backpressure: stalls on uart_tx_data_rdy_i / wr_data_vld_i / uart_rx_data_vld_i; req_rdy_o low while busy.
//
// Optional feature: define CMD_HOST_TIMEOUT_EN to abort a stalled response after TIMEOUT_CYCLES idle clocks
// (err_o and done_o pulse together); without it err_o is tied low.
//
// Ports:
//   clk_i, rst_n_i                       : clock, async active-low reset
//   req_cmd_i/conf_i/len_i/vld_i/rdy_o   : command request (conf word0 = low XLEN bits)
//   wr_data_i/vld_i/rdy_o                : DATA_WR payload byte stream
//   uart_tx_data_o/vld_o/rdy_i           : byte stream to the UART transmitter
//   uart_rx_data_i/vld_i/rdy_o           : byte stream from the UART receiver
//   rd_data_o/rd_data_vld_o              : response bytes (one-cycle strobe each)
//   done_o / err_o                       : completion pulse / timeout-abort pulse
module cmd_host
  import cmd_pkg::*;
#(
  parameter int          XLEN           = 32,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [7:0]        req_cmd_i,
  input  logic [2*XLEN-1:0] req_conf_i,
  input  logic [XLEN-1:0]   req_len_i,
  input  logic              req_vld_i,
  output logic              req_rdy_o,
  input  logic [7:0]        wr_data_i,
  input  logic              wr_data_vld_i,
  output logic              wr_data_rdy_o,
  output logic [7:0]        uart_tx_data_o,
  output logic              uart_tx_data_vld_o,
  input  logic              uart_tx_data_rdy_i,
  input  logic [7:0]        uart_rx_data_i,
  input  logic              uart_rx_data_vld_i,
  output logic              uart_rx_data_rdy_o,
  output logic [7:0]        rd_data_o,
  output logic              rd_data_vld_o,
  output logic              done_o,
  output logic              err_o
);

  state_t            state_q;
  logic [7:0]        cmd_q;
  logic [2*XLEN-1:0] conf_q;
  logic [XLEN-1:0]   len_q;
  logic [XLEN-1:0]   cnt_q;   // remaining payload / response bytes
  logic [2:0]        idx_q;   // config byte index

  logic tx_xfer;
  logic rx_xfer;

  assign tx_xfer = uart_tx_data_vld_o && uart_tx_data_rdy_i;
  assign rx_xfer = uart_rx_data_vld_i && uart_rx_data_rdy_o;

  // The receiver is only drained while a response is expected; stray bytes stay pending.
  assign uart_rx_data_rdy_o = (state_q == ST_RDATA);

  // Transmit mux. Write payload is a straight pass-through so no byte is buffered here.
  always_comb begin
    uart_tx_data_o     = 8'h00;
    uart_tx_data_vld_o = 1'b0;
    wr_data_rdy_o      = 1'b0;
    case (state_q)
      ST_CMD: begin
        uart_tx_data_o     = cmd_q;
        uart_tx_data_vld_o = 1'b1;
      end
      ST_CONF: begin
        uart_tx_data_o     = conf_q[{idx_q, 3'b000} +: 8];
        uart_tx_data_vld_o = 1'b1;
      end
      ST_WDATA: begin
        uart_tx_data_o     = wr_data_i;
        uart_tx_data_vld_o = wr_data_vld_i;
        wr_data_rdy_o      = uart_tx_data_rdy_i;
      end
      default: ;
    endcase
  end

`ifdef CMD_HOST_TIMEOUT_EN
  logic tmo;

  cmd_host_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .run_i     (state_q == ST_RDATA),
    .clr_i     (rx_xfer),
    .expired_o (tmo)
  );
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= ST_IDLE;
      cmd_q         <= '0;
      conf_q        <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      idx_q         <= '0;
      rd_data_o     <= '0;
      rd_data_vld_o <= 1'b0;
      done_o        <= 1'b0;
      req_rdy_o     <= 1'b1;
`ifdef CMD_HOST_TIMEOUT_EN
      err_o         <= 1'b0;
`endif
    end else begin
      rd_data_vld_o <= 1'b0;
      done_o        <= 1'b0;
`ifdef CMD_HOST_TIMEOUT_EN
      err_o         <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (req_vld_i) begin
            cmd_q     <= req_cmd_i;
            conf_q    <= req_conf_i;
            len_q     <= req_len_i;
            req_rdy_o <= 1'b0;
            state_q   <= ST_CMD;
          end
        end

        ST_CMD: begin
          if (tx_xfer) begin
            // Zero-length transfers and unknown opcodes end after the opcode byte.
            state_q <= ST_DONE;
            done_o  <= 1'b1;
            case (cmd_q)
              CONF_WR: begin
                idx_q   <= '0;
                state_q <= ST_CONF;
                done_o  <= 1'b0;
              end
              CONF_RD: begin
                cnt_q   <= XLEN'(CONF_BYTES);
                state_q <= ST_RDATA;
                done_o  <= 1'b0;
              end
              DATA_WR, DATA_RD: begin
                if (len_q != '0) begin
                  cnt_q   <= len_q;
                  state_q <= (cmd_q == DATA_WR) ? ST_WDATA : ST_RDATA;
                  done_o  <= 1'b0;
                end
              end
              default: ;
            endcase
          end
        end

        ST_CONF: begin
          if (tx_xfer) begin
            idx_q <= idx_q + 3'd1;
            if (idx_q == 3'(CONF_BYTES - 1)) begin
              state_q <= ST_DONE;
              done_o  <= 1'b1;
            end
          end
        end

        ST_WDATA: begin
          if (tx_xfer) begin
            cnt_q <= cnt_q - 1'b1;
            // Compare against 1 before decrementing so a full-scale length never wraps.
            if (cnt_q == XLEN'(1)) begin
              state_q <= ST_DONE;
              done_o  <= 1'b1;
            end
          end
        end

        ST_RDATA: begin
          if (rx_xfer) begin
            rd_data_o     <= uart_rx_data_i;
            rd_data_vld_o <= 1'b1;
            cnt_q         <= cnt_q - 1'b1;
            if (cnt_q == XLEN'(1)) begin
              state_q <= ST_DONE;
              done_o  <= 1'b1;
            end
          end
`ifdef CMD_HOST_TIMEOUT_EN
          else if (tmo) begin
            state_q <= ST_DONE;
            done_o  <= 1'b1;
            err_o   <= 1'b1;
          end
`endif
        end

        ST_DONE: begin
          state_q   <= ST_IDLE;
          req_rdy_o <= 1'b1;
        end

        default: begin
          state_q   <= ST_IDLE;
          req_rdy_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_host.sv
// Directed bench for cmd_host: drives requests, payload and response streams, logs the tx stream.
// Latency: n/a (testbench).
// Backpressure: tx sink readiness and write-payload validity are gapped by fixed patterns.
module tb_cmd_host;
  import cmd_pkg::*;

  localparam int XLEN = 32;

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic [7:0]        req_cmd_i;
  logic [2*XLEN-1:0] req_conf_i;
  logic [XLEN-1:0]   req_len_i;
  logic              req_vld_i;
  logic              req_rdy_o;
  logic [7:0]        wr_data_i;
  logic              wr_data_vld_i;
  logic              wr_data_rdy_o;
  logic [7:0]        uart_tx_data_o;
  logic              uart_tx_data_vld_o;
  logic              uart_tx_data_rdy_i;
  logic [7:0]        uart_rx_data_i;
  logic              uart_rx_data_vld_i;
  logic              uart_rx_data_rdy_o;
  logic [7:0]        rd_data_o;
  logic              rd_data_vld_o;
  logic              done_o;
  logic              err_o;

  always #5 clk_i = ~clk_i;

  cmd_host #(.XLEN(XLEN), .TIMEOUT_CYCLES(32'd100)) dut (
    .clk_i              (clk_i),
    .rst_n_i            (rst_n_i),
    .req_cmd_i          (req_cmd_i),
    .req_conf_i         (req_conf_i),
    .req_len_i          (req_len_i),
    .req_vld_i          (req_vld_i),
    .req_rdy_o          (req_rdy_o),
    .wr_data_i          (wr_data_i),
    .wr_data_vld_i      (wr_data_vld_i),
    .wr_data_rdy_o      (wr_data_rdy_o),
    .uart_tx_data_o     (uart_tx_data_o),
    .uart_tx_data_vld_o (uart_tx_data_vld_o),
    .uart_tx_data_rdy_i (uart_tx_data_rdy_i),
    .uart_rx_data_i     (uart_rx_data_i),
    .uart_rx_data_vld_i (uart_rx_data_vld_i),
    .uart_rx_data_rdy_o (uart_rx_data_rdy_o),
    .rd_data_o          (rd_data_o),
    .rd_data_vld_o      (rd_data_vld_o),
    .done_o             (done_o),
    .err_o              (err_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor (samples on the falling edge) ----------------
  int cyc = 0, done_cnt = 0, err_cnt = 0, rx_cnt = 0, viol = 0;
  int last_tx_cyc = 0, last_rd_cyc = 0, done_cyc = 0, err_cyc = 0;
  logic tx_x = 1'b0, wr_x = 1'b0, rx_x = 1'b0, req_x = 1'b0;
  logic [7:0] tx_q[$];
  logic [7:0] rd_q[$];

  always @(negedge clk_i) begin
    cyc++;
    tx_x  = uart_tx_data_vld_o && uart_tx_data_rdy_i;
    wr_x  = wr_data_vld_i && wr_data_rdy_o;
    rx_x  = uart_rx_data_vld_i && uart_rx_data_rdy_o;
    req_x = req_vld_i && req_rdy_o;
    if (tx_x) begin tx_q.push_back(uart_tx_data_o); last_tx_cyc = cyc; end
    if (rx_x) rx_cnt++;
    if (rd_data_vld_o) begin rd_q.push_back(rd_data_o); last_rd_cyc = cyc; end
    if (done_o) begin done_cnt++; done_cyc = cyc; end
    if (err_o) begin err_cnt++; err_cyc = cyc; end
    if (uart_tx_data_vld_o && uart_rx_data_rdy_o) viol++;
  end

  // ---------------- stimulus sources ----------------
  logic [7:0] rx_src[$];
  logic [7:0] wr_src[$];
  int  scyc = 0;
  bit  gap = 0, toggle = 0;

  task automatic step();
    @(posedge clk_i);
    #1;
    scyc++;
    if (rx_x) void'(rx_src.pop_front());
    if (wr_x) void'(wr_src.pop_front());
    uart_rx_data_vld_i = (rx_src.size() > 0);
    uart_rx_data_i     = (rx_src.size() > 0) ? rx_src[0] : 8'h00;
    // A pending payload byte stays valid until it transfers.
    if (!(wr_data_vld_i && !wr_x))
      wr_data_vld_i = (wr_src.size() > 0) && (!gap || (scyc % 3 != 0));
    wr_data_i          = (wr_src.size() > 0) ? wr_src[0] : 8'h00;
    uart_tx_data_rdy_i = toggle ? ((scyc % 2) == 1) : 1'b1;
  endtask

  task automatic run_cmd(input string tag, input logic [7:0] cmd,
                         input logic [63:0] conf, input logic [31:0] len);
    int n;
    int d0;
    bit to;
    tx_q.delete();
    rd_q.delete();
    req_cmd_i  = cmd;
    req_conf_i = conf;
    req_len_i  = len;
    req_vld_i  = 1'b1;
    to = 0;
    n  = 0;
    do begin
      step();
      n++;
    end while (!req_x && n < 50);
    req_vld_i = 1'b0;
    chk({tag, " busy_rdy"}, {31'd0, req_rdy_o}, 32'd0);
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < 400) begin
      step();
      n++;
    end
    to = (done_cnt == d0);
    chk({tag, " finished"}, {31'd0, to}, 32'd0);
  endtask

  task automatic check_q(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
    chk({tag, " len"}, got.size(), exp.size());
    foreach (exp[i])
      if (i < got.size()) chk($sformatf("%s byte%0d", tag, i), {24'd0, got[i]}, {24'd0, exp[i]});
  endtask

  initial begin
    int d0;
    int n;
    rst_n_i            = 1'b0;
    req_cmd_i          = '0;
    req_conf_i         = '0;
    req_len_i          = '0;
    req_vld_i          = 1'b0;
    wr_data_i          = '0;
    wr_data_vld_i      = 1'b0;
    uart_tx_data_rdy_i = 1'b1;
    uart_rx_data_i     = '0;
    uart_rx_data_vld_i = 1'b0;
    repeat (3) step();

    // reset values
    chk("rst req_rdy", {31'd0, req_rdy_o}, 32'd1);
    chk("rst tx_vld",  {31'd0, uart_tx_data_vld_o}, 32'd0);
    chk("rst rx_rdy",  {31'd0, uart_rx_data_rdy_o}, 32'd0);
    chk("rst outs",    {28'd0, done_o, err_o, rd_data_vld_o, wr_data_rdy_o}, 32'd0);
    rst_n_i = 1'b1;
    step();

    // CPU_RST with a stray byte pending on the receiver
    rx_src.push_back(8'h55);
    rx_cnt = 0;
    run_cmd("cpu_rst", 8'h2a, 64'd0, 32'd0);
    check_q("cpu_rst tx", tx_q, '{8'h2a});
    chk("cpu_rst done_lat", done_cyc - last_tx_cyc, 32'd1);
    chk("cpu_rst rx_untouched", rx_cnt, 32'd0);
    rx_src.delete();
    step();

    // CONF_WR: word1 = 0000_001f, word0 = 4000_0000
    d0 = done_cnt;
    run_cmd("conf_wr", 8'h2c, {32'h0000_001f, 32'h4000_0000}, 32'd0);
    check_q("conf_wr tx", tx_q, '{8'h2c, 8'h00, 8'h00, 8'h00, 8'h40, 8'h1f, 8'h00, 8'h00, 8'h00});
    step();
    chk("conf_wr done_once", done_cnt - d0, 32'd1);

    // DATA_WR len 4 with gapped payload and toggling tx readiness
    gap = 1; toggle = 1;
    wr_src = '{8'haa, 8'hbb, 8'hcc, 8'hdd};
    run_cmd("data_wr", 8'h2e, 64'd0, 32'd4);
    check_q("data_wr tx", tx_q, '{8'h2e, 8'haa, 8'hbb, 8'hcc, 8'hdd});
    chk("data_wr done_lat", done_cyc - last_tx_cyc, 32'd1);
    gap = 0; toggle = 0;
    step();

    // DATA_WR len 0: opcode only
    run_cmd("data_wr0", 8'h2e, 64'd0, 32'd0);
    check_q("data_wr0 tx", tx_q, '{8'h2e});

    // DATA_RD len 3
    rx_src = '{8'h11, 8'h22, 8'h33};
    rx_cnt = 0;
    run_cmd("data_rd", 8'h2f, 64'd0, 32'd3);
    check_q("data_rd tx", tx_q, '{8'h2f});
    check_q("data_rd rd", rd_q, '{8'h11, 8'h22, 8'h33});
    chk("data_rd done_with_last", done_cyc - last_rd_cyc, 32'd0);
    chk("data_rd rx_cnt", rx_cnt, 32'd3);

    // CONF_RD: eight response bytes
    rx_src = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_cmd("conf_rd", 8'h2d, 64'd0, 32'd0);
    check_q("conf_rd rd", rd_q, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08});

    // Unknown opcode: single byte then done
    run_cmd("unk", 8'h99, 64'd0, 32'd7);
    check_q("unk tx", tx_q, '{8'h99});

    // Reset during CONF byte 4, then CPU_RUN
    tx_q.delete();
    d0 = done_cnt;
    req_cmd_i  = 8'h2c;
    req_conf_i = 64'h0123_4567_89ab_cdef;
    req_vld_i  = 1'b1;
    n = 0;
    do begin
      step();
      if (req_x) req_vld_i = 1'b0;
      n++;
    end while (tx_q.size() < 5 && n < 50);
    req_vld_i = 1'b0;
    rst_n_i = 1'b0;
    #2;
    chk("midrst req_rdy", {31'd0, req_rdy_o}, 32'd1);
    chk("midrst tx_vld",  {31'd0, uart_tx_data_vld_o}, 32'd0);
    chk("midrst done",    {31'd0, done_o}, 32'd0);
    step();
    rst_n_i = 1'b1;
    step();
    chk("midrst no_done", done_cnt - d0, 32'd0);
    run_cmd("cpu_run", 8'h2b, 64'd0, 32'd0);
    check_q("cpu_run tx", tx_q, '{8'h2b});

`ifdef CMD_HOST_TIMEOUT_EN
    // CONF_RD with no reply: abort 100 cycles into the response phase (entry cycle = 0)
    rx_src.delete();
    d0 = err_cnt;
    run_cmd("tmo", 8'h2d, 64'd0, 32'd0);
    chk("tmo err_once", err_cnt - d0, 32'd1);
    chk("tmo err_with_done", err_cyc - done_cyc, 32'd0);
    chk("tmo err_lat", err_cyc - last_tx_cyc, 32'd101);
    #1;
    chk("tmo req_rdy_next", {31'd0, req_rdy_o}, 32'd1);
`else
    chk("no_err", err_cnt, 32'd0);
`endif

    chk("tx_rx_exclusive", viol, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
